guess_game_ctrl: RTL and testbench

Synchronous sequencer for the two-player number-guessing game. It takes the four symbol buttons and the enter button as level inputs and converts them to single-cycle presses. It collects player A's secret sequence, then gives player B up to MAX_TURNS guesses and compares each guess against the secret. It sits between the debounced front-panel buttons and the win/lose/length indicator LEDs, and replaces the edge-triggered entry logic with one clocked FSM.

---
 rtl/guess_game_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_guess_game_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/guess_game_ctrl.sv
// Two-player number-guessing sequencer. It edge-detects the front-panel buttons,
// records player A's secret, then scores up to MAX_TURNS guesses from player B.
module guess_game_ctrl #(
   parameter int MAX_LEN   = 7,
   parameter int MIN_LEN   = 4,
   parameter int MAX_TURNS = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       I1,
   input  logic       I2,
   input  logic       I3,
   input  logic       I4,
   input  logic       enter,
   output logic [2:0] state,
   output logic [3:0] numa,
   output logic [3:0] numb,
   output logic [1:0] turn,
   output logic [6:0] suc,
   output logic       win,
   output logic       lose,
   output logic       equal,
   output logic       bigger,
   output logic       smaller
);

   localparam logic [3:0] LP_MAX_LEN   = 4'(MAX_LEN);
   localparam logic [3:0] LP_MIN_LEN   = 4'(MIN_LEN);
   localparam logic [1:0] LP_MAX_TURNS = 2'(MAX_TURNS);

   typedef enum logic [2:0] {
      ST_ENTER_A = 3'd0,
      ST_ENTER_B = 3'd1,
      ST_CHECK   = 3'd2,
      ST_WON     = 3'd3,
      ST_LOST    = 3'd4
   } state_t;

   state_t                    r_state;
   state_t                    w_state_next;
   logic [4:0]                r_prev;
   logic [3:0]                r_numa;
   logic [3:0]                r_numb;
   logic [1:0]                r_turn;
   logic [6:0]                r_suc;
   logic                      r_win;
   logic                      r_lose;
   logic                      r_equal;
   logic                      r_bigger;
   logic                      r_smaller;
   logic [MAX_LEN-1:0]        r_sec_vld;
   logic [MAX_LEN-1:0][1:0]   r_sec_code;
   logic [MAX_LEN-1:0]        r_gss_vld;
   logic [MAX_LEN-1:0][1:0]   r_gss_code;

   logic [3:0] w_sym_press;
   logic       w_enter_press;
   logic       w_sym_valid;
   logic [1:0] w_sym_code;
   logic [6:0] w_suc;
   logic       w_win_n;
   logic [1:0] w_turn_inc;
   logic       w_last_turn;
   logic       w_store_a;
   logic       w_store_b;
   logic       w_do_check;
   logic       w_restart;

   assign w_sym_press   = {I4, I3, I2, I1} & ~r_prev[3:0];
   assign w_enter_press = enter & ~r_prev[4];

   // Only a lone symbol press counts; simultaneous presses are all dropped.
   always_comb begin
      w_sym_valid = 1'b1;
      w_sym_code  = 2'd0;
      case (w_sym_press)
         4'b0001: w_sym_code = 2'd0;
         4'b0010: w_sym_code = 2'd1;
         4'b0100: w_sym_code = 2'd2;
         4'b1000: w_sym_code = 2'd3;
         default: w_sym_valid = 1'b0;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 7; gi++) begin : g_suc
         if (gi < MAX_LEN) begin : g_slot
            assign w_suc[gi] = (r_sec_vld[gi] == r_gss_vld[gi]) &&
                               (!r_sec_vld[gi] || (r_sec_code[gi] == r_gss_code[gi]));
         end else begin : g_pad
            assign w_suc[gi] = 1'b1;
         end
      end
   endgenerate

   assign w_win_n     = &w_suc;
   assign w_turn_inc  = r_turn + 2'd1;
   assign w_last_turn = (w_turn_inc == LP_MAX_TURNS);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_ENTER_A;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_store_a    = 1'b0;
      w_store_b    = 1'b0;
      w_do_check   = 1'b0;
      w_restart    = 1'b0;
      case (r_state)
         ST_ENTER_A: begin
            if (w_sym_valid) begin
               w_store_a = 1'b1;
               if (r_numa + 4'd1 == LP_MAX_LEN) w_state_next = ST_ENTER_B;
            end else if (w_enter_press && r_numa >= LP_MIN_LEN) begin
               w_state_next = ST_ENTER_B;
            end
         end
         ST_ENTER_B: begin
            // A symbol press always shadows a coincident enter, even when the guess is full.
            if (w_sym_valid) begin
               if (r_numb < LP_MAX_LEN) w_store_b = 1'b1;
            end else if (w_enter_press && r_numb >= LP_MIN_LEN) begin
               w_state_next = ST_CHECK;
            end
         end
         ST_CHECK: begin
            w_do_check = 1'b1;
            if (w_win_n)          w_state_next = ST_WON;
            else if (w_last_turn) w_state_next = ST_LOST;
            else                  w_state_next = ST_ENTER_B;
         end
         ST_WON, ST_LOST: begin
            if (w_enter_press) begin
               w_restart    = 1'b1;
               w_state_next = ST_ENTER_A;
            end
         end
         default: w_state_next = ST_ENTER_A;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prev     <= '0;
         r_numa     <= '0;
         r_numb     <= '0;
         r_turn     <= '0;
         r_suc      <= '0;
         r_win      <= 1'b0;
         r_lose     <= 1'b0;
         r_equal    <= 1'b0;
         r_bigger   <= 1'b0;
         r_smaller  <= 1'b0;
         r_sec_vld  <= '0;
         r_sec_code <= '0;
         r_gss_vld  <= '0;
         r_gss_code <= '0;
      end else begin
         // Edge registers keep tracking the buttons across a restart so a held key cannot re-fire.
         r_prev <= {enter, I4, I3, I2, I1};
         if (w_restart) begin
            r_numa     <= '0;
            r_numb     <= '0;
            r_turn     <= '0;
            r_suc      <= '0;
            r_win      <= 1'b0;
            r_lose     <= 1'b0;
            r_equal    <= 1'b0;
            r_bigger   <= 1'b0;
            r_smaller  <= 1'b0;
            r_sec_vld  <= '0;
            r_sec_code <= '0;
            r_gss_vld  <= '0;
            r_gss_code <= '0;
         end else begin
            if (w_store_a) begin
               r_sec_vld[r_numa[2:0]]  <= 1'b1;
               r_sec_code[r_numa[2:0]] <= w_sym_code;
               r_numa                  <= r_numa + 4'd1;
            end
            if (w_store_b) begin
               r_gss_vld[r_numb[2:0]]  <= 1'b1;
               r_gss_code[r_numb[2:0]] <= w_sym_code;
               r_numb                  <= r_numb + 4'd1;
            end
            if (w_do_check) begin
               r_suc     <= w_suc;
               r_smaller <= (r_numb > r_numa);
               r_equal   <= (r_numb == r_numa);
               r_bigger  <= (r_numb < r_numa);
               if (r_turn != LP_MAX_TURNS) r_turn <= w_turn_inc;
               r_win     <= w_win_n;
               r_lose    <= !w_win_n && w_last_turn;
               if (!w_win_n && !w_last_turn) begin
                  r_numb     <= '0;
                  r_gss_vld  <= '0;
                  r_gss_code <= '0;
               end
            end
         end
      end
   end

   assign state   = r_state;
   assign numa    = r_numa;
   assign numb    = r_numb;
   assign turn    = r_turn;
   assign suc     = r_suc;
   assign win     = r_win;
   assign lose    = r_lose;
   assign equal   = r_equal;
   assign bigger  = r_bigger;
   assign smaller = r_smaller;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed bench for guess_game_ctrl: stimulus queues hand-computed output snapshots,
// a negedge monitor pops and compares each one in the cycle it falls due.
module tb_guess_game_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       I1 = 1'b0, I2 = 1'b0, I3 = 1'b0, I4 = 1'b0, enter = 1'b0;
   logic [2:0] state;
   logic [3:0] numa, numb;
   logic [1:0] turn;
   logic [6:0] suc;
   logic       win, lose, equal, bigger, smaller;

   typedef struct packed {
      logic [2:0] st;
      logic [3:0] na;
      logic [3:0] nb;
      logic [1:0] tu;
      logic [6:0] su;
      logic       win;
      logic       lose;
      logic       eq;
      logic       bg;
      logic       sm;
   } snap_t;

   typedef struct {
      string name;
      int    due;
      snap_t exp;
   } item_t;

   item_t sb[$];
   snap_t e;
   int    cyc = 0;
   int    checks = 0;
   int    errors = 0;

   guess_game_ctrl #(.MAX_LEN(7), .MIN_LEN(4), .MAX_TURNS(3)) dut (
      .clk(clk), .reset(reset),
      .I1(I1), .I2(I2), .I3(I3), .I4(I4), .enter(enter),
      .state(state), .numa(numa), .numb(numb), .turn(turn), .suc(suc),
      .win(win), .lose(lose), .equal(equal), .bigger(bigger), .smaller(smaller)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : monitor
      item_t it;
      snap_t act;
      act = {state, numa, numb, turn, suc, win, lose, equal, bigger, smaller};
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         it = sb.pop_front();
         checks++;
         if (it.due != cyc) begin
            errors++;
            $display("FAIL %s checked late: cycle %0d, due %0d", it.name, cyc, it.due);
         end else if (act !== it.exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h (st=%0d na=%0d nb=%0d tu=%0d suc=%h w=%b l=%b e/b/s=%b%b%b)",
                     it.name, act, it.exp, state, numa, numb, turn, suc, win, lose, equal, bigger, smaller);
         end else begin
            $display("ok   %s snap=%h", it.name, act);
         end
      end
   end

   task automatic push(input string n);
      sb.push_back('{name: n, due: cyc, exp: e});
   endtask

   // Drive {enter,I4,I3,I2,I1} for one rising edge; returns just after that edge.
   task automatic tick(input logic [4:0] b);
      @(negedge clk);
      {enter, I4, I3, I2, I1} = b;
      @(posedge clk);
      #1;
   endtask

   task automatic sym(input int n);
      tick(5'(1 << n));
      tick(5'b0);
   endtask

   initial begin
      e = '0;
      tick(5'b0);
      push("reset_state");
      @(negedge clk);
      reset = 1'b1;

      // Matching 4-symbol game ends in WON
      tick(5'b00001); e.na = 4'd1; push("press_latency");
      tick(5'b0);
      sym(1); sym(2); sym(3);
      e.na = 4'd4; push("secret_len4");
      tick(5'b10000); e.st = 3'd1; push("enter_a_to_b");
      tick(5'b0);
      sym(0); sym(1); sym(2); sym(3);
      e.nb = 4'd4; push("guess_len4");
      tick(5'b10000); e.st = 3'd2; push("check_state");
      tick(5'b0);
      e.st = 3'd3; e.su = 7'h7F; e.eq = 1'b1; e.win = 1'b1; e.tu = 2'd1;
      push("won");
      sym(2); push("won_hold");
      tick(5'b10000); e = '0; push("won_restart");
      tick(5'b0);

      // Three wrong 5-symbol guesses end in LOST
      sym(0); sym(0); sym(0); sym(0);
      tick(5'b10000); e.na = 4'd4; e.st = 3'd1; push("lost_secret");
      tick(5'b0);
      for (int g = 1; g <= 3; g++) begin
         for (int k = 0; k < 5; k++) sym(3);
         e.nb = 4'd5; push($sformatf("guess%0d_len5", g));
         tick(5'b10000);
         e.st = 3'd2; push($sformatf("guess%0d_check", g));
         tick(5'b0);
         e.su = 7'h60; e.sm = 1'b1; e.tu = 2'(g);
         if (g < 3) begin
            e.st = 3'd1; e.nb = 4'd0;
         end else begin
            e.st = 3'd4; e.lose = 1'b1;
         end
         push($sformatf("guess%0d_result", g));
      end
      sym(1); push("lost_hold");
      tick(5'b10000); e = '0; push("lost_restart");
      tick(5'b0);

      // 7-symbol secret auto-advances; full guess ignores extra symbols
      sym(0); sym(1); sym(2); sym(3); sym(0); sym(1);
      tick(5'b00100); e.na = 4'd7; e.st = 3'd1; push("secret_full_auto_b");
      tick(5'b0);
      sym(3); e.nb = 4'd1; push("eighth_press_to_guess");
      for (int k = 0; k < 7; k++) sym(k % 4);
      e.nb = 4'd7; push("guess_saturates_no_check");
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1; e = '0; push("sync_reset_clear");
      @(negedge clk); reset = 1'b1;

      // Entry corner cases
      sym(0); sym(1); sym(2);
      tick(5'b10000); e.na = 4'd3; push("enter_short_ignored");
      tick(5'b0);
      tick(5'b00011); push("double_press_dropped");
      tick(5'b0);
      tick(5'b10100); e.na = 4'd4; push("sym_beats_enter");
      tick(5'b0);
      for (int k = 0; k < 10; k++) tick(5'b00001);
      e.na = 4'd5; push("held_button_once");
      tick(5'b0);
      tick(5'b10000); e.st = 3'd1; push("enter_len5");
      tick(5'b0);
      sym(0); sym(1);
      tick(5'b10000); e.nb = 4'd2; push("enter_b_short_ignored");
      tick(5'b0);
      // Asynchronous reset mid-cycle, checked before any further rising edge
      reset = 1'b0;
      e = '0; push("async_reset");
      @(negedge clk); #1;
      reset = 1'b1;

      for (int i = 0; i < 10 && sb.size() > 0; i++) begin
         @(negedge clk); #1;
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending=%0d want=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
